// File: rtl/multi_word_ram_writer.sv
// multi_word_ram_writer
// Packs a stream of DATA_WIDTH-bit beats into a multi-word RAM, NUM_WORDS
// words per row, DEPTH rows. A fill is launched by a one-cycle start pulse
// and completes after exactly DEPTH*NUM_WORDS accepted beats. The write
// port (data, row address, per-word enable) is registered, so each write
// appears the cycle after its beat is accepted. The final write is flagged
// by a one-cycle done pulse.
module multi_word_ram_writer #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 64,
  parameter int NUM_WORDS  = 4
) (
  input  logic                                       clk,
  input  logic                                       rst_n,
  input  logic                                       start,
  input  logic [DATA_WIDTH-1:0]                      i_data,
  input  logic                                       i_valid,
  output logic                                       o_ready,
  output logic [DATA_WIDTH-1:0]                      wr_data,
  output logic [((DEPTH > 1) ? $clog2(DEPTH) : 1)-1:0] wr_addr,
  output logic [NUM_WORDS-1:0]                       wr_en,
  output logic                                       busy,
  output logic                                       done
);

  // Counter widths; a single row or single word still needs a 1-bit counter.
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int WW = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

  // Terminal counts compared against explicitly so that non power-of-2
  // DEPTH / NUM_WORDS wrap at the right place instead of at 2**width.
  localparam logic [AW-1:0] ROW_LAST  = AW'(DEPTH - 1);
  localparam logic [WW-1:0] WORD_LAST = WW'(NUM_WORDS - 1);

  // FSM encoding
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WRITE = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  // Decode a word index into the per-word write-enable vector (word 0 = bit 0).
  function automatic logic [NUM_WORDS-1:0] f_word_onehot(input logic [WW-1:0] idx);
    logic [NUM_WORDS-1:0] v;
    v = '0;
    for (int k = 0; k < NUM_WORDS; k++) begin
      if (idx == WW'(k)) begin
        v[k] = 1'b1;
      end else begin
        v[k] = 1'b0;
      end
    end
    return v;
  endfunction

  // State and counters
  logic [1:0]            r_state;
  logic [1:0]            w_state_nxt;
  logic [AW-1:0]         r_row_cnt;
  logic [WW-1:0]         r_word_cnt;

  // Registered write port
  logic [DATA_WIDTH-1:0] r_wr_data;
  logic [AW-1:0]         r_wr_addr;
  logic [NUM_WORDS-1:0]  r_wr_en;
  logic                  r_done;

  // Handshake / terminal-count decodes
  logic                  w_ready;
  logic                  w_accept;
  logic                  w_last_word;
  logic                  w_last_row;
  logic                  w_last_beat;
  logic                  w_launch;

  assign w_ready     = (r_state == S_WRITE);
  assign w_accept    = i_valid & w_ready;
  assign w_last_word = (r_word_cnt == WORD_LAST);
  assign w_last_row  = (r_row_cnt == ROW_LAST);
  assign w_last_beat = w_last_word & w_last_row;
  // start only counts in IDLE; in WRITE and DONE it is ignored.
  assign w_launch    = (r_state == S_IDLE) & start;

  // Next-state logic for the IDLE -> WRITE -> DONE -> IDLE sequence.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = S_WRITE;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_WRITE: begin
        if (w_accept && w_last_beat) begin
          w_state_nxt = S_DONE;
        end else begin
          w_state_nxt = S_WRITE;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State register; reset abandons any fill in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Row/word position: cleared on launch, advanced by each accepted beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_row_cnt  <= '0;
      r_word_cnt <= '0;
    end else if (w_launch) begin
      r_row_cnt  <= '0;
      r_word_cnt <= '0;
    end else if (w_accept) begin
      if (w_last_word) begin
        r_word_cnt <= '0;
        if (w_last_row) begin
          r_row_cnt <= '0;
        end else begin
          r_row_cnt <= r_row_cnt + AW'(1);
        end
      end else begin
        r_word_cnt <= r_word_cnt + WW'(1);
      end
    end else begin
      r_row_cnt  <= r_row_cnt;
      r_word_cnt <= r_word_cnt;
    end
  end

  // Write port: one enable pulse per accepted beat; data/address hold between writes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_data <= '0;
      r_wr_addr <= '0;
      r_wr_en   <= '0;
    end else if (w_accept) begin
      r_wr_data <= i_data;
      r_wr_addr <= r_row_cnt;
      r_wr_en   <= f_word_onehot(r_word_cnt);
    end else begin
      r_wr_data <= r_wr_data;
      r_wr_addr <= r_wr_addr;
      r_wr_en   <= '0;
    end
  end

  // done is registered alongside the final write so the two line up exactly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_done <= 1'b0;
    end else begin
      r_done <= w_accept & w_last_beat;
    end
  end

  assign o_ready = w_ready;
  assign busy    = (r_state != S_IDLE);
  assign wr_data = r_wr_data;
  assign wr_addr = r_wr_addr;
  assign wr_en   = r_wr_en;
  assign done    = r_done;

endmodule

// File: tb/tb_multi_word_ram_writer.sv
// Self-checking bench for multi_word_ram_writer (DATA_WIDTH=8, DEPTH=4,
// NUM_WORDS=2). A behavioural model pushes each expected write into a
// scoreboard queue as the beat is driven; a negedge monitor pops and
// compares against the DUT write port and also checks o_ready/busy/done
// every cycle. Scenario code adds explicit checks on the logged writes.
module tb_multi_word_ram_writer;

  typedef struct packed {
    logic [1:0] addr;
    logic [1:0] en;
    logic [7:0] data;
    logic       done;
  } wr_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] i_data = 8'h00;
  logic       i_valid = 1'b0;
  logic       o_ready;
  logic [7:0] wr_data;
  logic [1:0] wr_addr;
  logic [1:0] wr_en;
  logic       busy;
  logic       done;

  int n_checks = 0;
  int n_errors = 0;
  int n_done   = 0;

  wr_t exp_q[$];
  wr_t wlog[$];

  // model state: 0 idle, 1 write, 2 done
  logic [1:0] m_state = 2'd0;
  logic [1:0] m_row   = 2'd0;
  logic       m_word  = 1'b0;

  multi_word_ram_writer #(
    .DATA_WIDTH(8),
    .DEPTH     (4),
    .NUM_WORDS (2)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .i_data (i_data),
    .i_valid(i_valid),
    .o_ready(o_ready),
    .wr_data(wr_data),
    .wr_addr(wr_addr),
    .wr_en  (wr_en),
    .busy   (busy),
    .done   (done)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Reference model: tracks the fill and queues the write each accepted beat must produce.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_state <= 2'd0;
      m_row   <= 2'd0;
      m_word  <= 1'b0;
      exp_q.delete();
    end else begin
      case (m_state)
        2'd0: begin
          if (start) begin
            m_state <= 2'd1;
            m_row   <= 2'd0;
            m_word  <= 1'b0;
          end
        end
        2'd1: begin
          if (i_valid) begin
            exp_q.push_back('{addr: m_row, en: (m_word ? 2'b10 : 2'b01),
                              data: i_data, done: (m_row == 2'd3 && m_word)});
            if (m_word) begin
              m_word <= 1'b0;
              if (m_row == 2'd3) begin
                m_state <= 2'd2;
              end else begin
                m_row <= m_row + 2'd1;
              end
            end else begin
              m_word <= 1'b1;
            end
          end
        end
        default: m_state <= 2'd0;
      endcase
    end
  end

  task automatic monitor_cycle();
    wr_t  e;
    logic have;
    logic want;
    have = (wr_en != 2'b00);
    want = (exp_q.size() != 0);
    check_eq("o_ready", {31'd0, o_ready}, {31'd0, (m_state == 2'd1)});
    check_eq("busy", {31'd0, busy}, {31'd0, (m_state != 2'd0)});
    check_eq("write_present", {31'd0, have}, {31'd0, want});
    if (want) begin
      e = exp_q.pop_front();
      if (have) begin
        check_eq("wr_addr", {30'd0, wr_addr}, {30'd0, e.addr});
        check_eq("wr_en", {30'd0, wr_en}, {30'd0, e.en});
        check_eq("wr_data", {24'd0, wr_data}, {24'd0, e.data});
        check_eq("done", {31'd0, done}, {31'd0, e.done});
      end
    end else begin
      check_eq("done_no_write", {31'd0, done}, 32'd0);
    end
    if (have) begin
      wlog.push_back('{addr: wr_addr, en: wr_en, data: wr_data, done: done});
    end
    if (done) begin
      n_done++;
    end
  endtask

  // Monitor samples mid-cycle, away from the rising edge.
  always @(negedge clk) monitor_cycle();

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic beat(input logic [7:0] d);
    i_valid = 1'b1;
    i_data  = d;
    tick();
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_wr_en", {30'd0, wr_en}, 32'd0);
    check_eq("rst_wr_addr", {30'd0, wr_addr}, 32'd0);
    check_eq("rst_wr_data", {24'd0, wr_data}, 32'd0);
    check_eq("rst_done", {31'd0, done}, 32'd0);
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    check_eq("rst_o_ready", {31'd0, o_ready}, 32'd0);
    rst_n = 1'b1;
    tick();

    // Idle input before any start is never consumed
    wlog.delete();
    i_valid = 1'b1;
    i_data  = 8'hAA;
    repeat (4) tick();
    i_valid = 1'b0;
    check_eq("idle_writes", wlog.size(), 32'd0);

    // Full fill, back-to-back beats, against the literal write sequence
    wlog.delete();
    n_done = 0;
    pulse_start();
    for (int k = 0; k < 8; k++) beat(8'h10 + 8'(k));
    i_valid = 1'b0;
    repeat (3) tick();
    check_eq("full_count", wlog.size(), 32'd8);
    for (int k = 0; k < 8 && k < wlog.size(); k++) begin
      check_eq("full_addr", {30'd0, wlog[k].addr}, 32'(k / 2));
      check_eq("full_en", {30'd0, wlog[k].en}, ((k % 2) == 1) ? 32'd2 : 32'd1);
      check_eq("full_data", {24'd0, wlog[k].data}, 32'h10 + 32'(k));
      check_eq("full_done", {31'd0, wlog[k].done}, (k == 7) ? 32'd1 : 32'd0);
    end
    check_eq("full_done_pulses", n_done, 32'd1);

    // Stalls: valid pattern 1,0,0,1,0,0,...
    wlog.delete();
    n_done = 0;
    pulse_start();
    begin
      int k;
      k = 0;
      for (int c = 0; c < 40 && k < 8; c++) begin
        i_valid = ((c % 3) == 0);
        i_data  = 8'h20 + 8'(k);
        tick();
        if ((c % 3) == 0) k++;
      end
    end
    i_valid = 1'b0;
    repeat (3) tick();
    check_eq("stall_count", wlog.size(), 32'd8);
    for (int k = 0; k < 8 && k < wlog.size(); k++) begin
      check_eq("stall_data", {24'd0, wlog[k].data}, 32'h20 + 32'(k));
    end
    check_eq("stall_done_pulses", n_done, 32'd1);

    // start re-pulsed mid-fill is ignored
    wlog.delete();
    n_done = 0;
    pulse_start();
    for (int k = 0; k < 8; k++) begin
      start = (k == 3);
      beat(8'h60 + 8'(k));
    end
    start   = 1'b0;
    i_valid = 1'b0;
    repeat (3) tick();
    check_eq("rebusy_count", wlog.size(), 32'd8);
    if (wlog.size() == 8) begin
      check_eq("rebusy_last_addr", {30'd0, wlog[7].addr}, 32'd3);
      check_eq("rebusy_beat4_addr", {30'd0, wlog[3].addr}, 32'd1);
    end
    check_eq("rebusy_done_pulses", n_done, 32'd1);

    // Reset in the middle of a fill
    n_done = 0;
    pulse_start();
    for (int k = 0; k < 5; k++) beat(8'h70 + 8'(k));
    i_valid = 1'b0;
    rst_n   = 1'b0;
    #1;
    check_eq("midrst_wr_en", {30'd0, wr_en}, 32'd0);
    check_eq("midrst_busy", {31'd0, busy}, 32'd0);
    check_eq("midrst_done", {31'd0, done}, 32'd0);
    check_eq("midrst_o_ready", {31'd0, o_ready}, 32'd0);
    check_eq("midrst_wr_addr", {30'd0, wr_addr}, 32'd0);
    repeat (2) tick();
    rst_n   = 1'b1;
    i_valid = 1'b1;
    i_data  = 8'h55;
    repeat (3) tick();
    i_valid = 1'b0;
    wlog.delete();
    pulse_start();
    beat(8'h31);
    i_valid = 1'b0;
    tick();
    check_eq("midrst_restart_count", wlog.size(), 32'd1);
    if (wlog.size() == 1) begin
      check_eq("midrst_restart_addr", {30'd0, wlog[0].addr}, 32'd0);
      check_eq("midrst_restart_en", {30'd0, wlog[0].en}, 32'd1);
      check_eq("midrst_restart_data", {24'd0, wlog[0].data}, 32'h31);
    end
    for (int k = 1; k < 8; k++) beat(8'h30 + 8'(k));
    i_valid = 1'b0;
    repeat (2) tick();

    // Back-to-back fills: start during DONE ignored, one cycle later accepted
    wlog.delete();
    n_done = 0;
    pulse_start();
    for (int k = 0; k < 8; k++) beat(8'h40 + 8'(k));
    i_valid = 1'b0;
    start   = 1'b1;
    tick();
    check_eq("b2b_idle_after_done", {31'd0, busy}, 32'd0);
    tick();
    start = 1'b0;
    for (int k = 0; k < 8; k++) beat(8'h50 + 8'(k));
    i_valid = 1'b0;
    repeat (3) tick();
    check_eq("b2b_count", wlog.size(), 32'd16);
    if (wlog.size() == 16) begin
      check_eq("b2b_first_last", {24'd0, wlog[7].data}, 32'h47);
      check_eq("b2b_second_addr", {30'd0, wlog[8].addr}, 32'd0);
      check_eq("b2b_second_en", {30'd0, wlog[8].en}, 32'd1);
      check_eq("b2b_second_data", {24'd0, wlog[8].data}, 32'h50);
    end
    check_eq("b2b_done_pulses", n_done, 32'd2);
    check_eq("scoreboard_empty", exp_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
